// File: rtl/dds_pkg.sv
// Shared definitions for the DDS datapath: waveform mode encoding and
// parameter legality checks.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_TRI  = 2'd1,
        MODE_SAW  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_e;

    function automatic bit widths_ok(input int unsigned acc_w,
                                     input int unsigned phase_w,
                                     input int unsigned data_w);
        return (acc_w >= phase_w) && (phase_w >= data_w + 1) &&
               (phase_w >= 4) && (data_w >= 2);
    endfunction

endpackage

// File: rtl/dds_sine_qrom.sv
// Quarter-wave sine magnitude ROM with a single registered read port;
// contents are computed at elaboration.
module dds_sine_qrom #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam longint      PI_Q30 = 64'sd3373259426;

    // round((2^DATA_W - 1) * sin(pi/2 * idx/DEPTH)) via a Q30 integer Taylor
    // series, so elaboration needs no real-valued math.
    function automatic logic [DATA_W-1:0] qsin(input int unsigned idx);
        longint x, x2, term, acc_q, amp;
        x     = (PI_Q30 * longint'(idx)) / (longint'(2) << ADDR_W);
        x2    = (x * x) >>> 30;
        term  = x;
        acc_q = x;
        for (int unsigned k = 1; k <= 7; k++) begin
            term  = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            acc_q = acc_q + term;
        end
        amp = (longint'(1) << DATA_W) - 1;
        return DATA_W'((amp * acc_q + (longint'(1) << 29)) >>> 30);
    endfunction

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_W-1:0] VAL = qsin(i);
        assign rom[i] = VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data <= '0;
        else if (rd_en)
            data <= rom[addr];
    end

endmodule

// File: rtl/dds_wave_gen.sv
// Multi-mode DDS: phase accumulator with handshaked (optionally wrap-aligned)
// config update, feeding a 3-stage sine/triangle/sawtooth/square pipeline.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W          = 32,
    parameter int unsigned PHASE_W        = 12,
    parameter int unsigned DATA_W         = 10,
    parameter bit          UPDATE_AT_WRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_fw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [1:0]         cfg_mode,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               wrap
);

    if (!widths_ok(ACC_W, PHASE_W, DATA_W)) begin : g_bad_widths
        $error("dds_wave_gen: need ACC_W >= PHASE_W >= DATA_W+1, PHASE_W >= 4");
    end

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [ACC_W-1:0]   fw_a, fw_s, acc, acc_sum;
    logic [PHASE_W-1:0] poff_a, poff_s, phase;
    mode_e              mode_a, mode_s;
    logic               pending, xfer, carry, step_wrap, apply;

    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, fw_a};
    assign step_wrap = en && !sync_clr && carry;
    assign cfg_ready = UPDATE_AT_WRAP ? !pending : 1'b1;
    assign xfer      = cfg_valid && cfg_ready;
    assign apply     = pending && (step_wrap || sync_clr);

    // apply and xfer are exclusive: a transfer needs !pending, an apply needs pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_a    <= '0;
            poff_a  <= '0;
            mode_a  <= MODE_SINE;
            fw_s    <= '0;
            poff_s  <= '0;
            mode_s  <= MODE_SINE;
            pending <= 1'b0;
        end else if (UPDATE_AT_WRAP) begin
            if (apply) begin
                fw_a    <= fw_s;
                poff_a  <= poff_s;
                mode_a  <= mode_s;
                pending <= 1'b0;
            end
            if (xfer) begin
                fw_s    <= cfg_fw;
                poff_s  <= cfg_poff;
                mode_s  <= mode_e'(cfg_mode);
                pending <= 1'b1;
            end
        end else if (xfer) begin
            fw_a   <= cfg_fw;
            poff_a <= cfg_poff;
            mode_a <= mode_e'(cfg_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= step_wrap;
            if (sync_clr)
                acc <= '0;
            else if (en)
                acc <= acc_sum;
        end
    end

    // Stage 1: phase and mode captured together so a mode change never splits a sample
    logic [PHASE_W-1:0] p1;
    mode_e              m1;
    logic               v1;

    assign phase = acc[ACC_W-1 -: PHASE_W] + poff_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0;
            m1 <= MODE_SINE;
            v1 <= 1'b0;
        end else begin
            v1 <= en;
            if (en) begin
                p1 <= phase;
                m1 <= mode_a;
            end
        end
    end

    // Stage 2: quarter-wave ROM read alongside the linear waveforms
    logic [PHASE_W-3:0] rom_addr;
    logic [DATA_W-2:0]  mag;
    logic [DATA_W-1:0]  lin_d, lin2;
    mode_e              m2;
    logic               q2, v2;

    always_comb begin
        rom_addr = p1[PHASE_W-2] ? ~p1[PHASE_W-3:0] : p1[PHASE_W-3:0];
        lin_d    = '0;
        unique case (m1)
            MODE_TRI: lin_d = p1[PHASE_W-1] ? ~p1[PHASE_W-2 -: DATA_W]
                                            :  p1[PHASE_W-2 -: DATA_W];
            MODE_SAW: lin_d = p1[PHASE_W-1 -: DATA_W];
            MODE_SQR: lin_d = {DATA_W{p1[PHASE_W-1]}};
            default:  lin_d = '0;
        endcase
    end

    dds_sine_qrom #(
        .ADDR_W(PHASE_W - 2),
        .DATA_W(DATA_W - 1)
    ) u_qrom (
        .clk  (clk),
        .rst_n(rst_n),
        .rd_en(v1),
        .addr (rom_addr),
        .data (mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin2 <= '0;
            m2   <= MODE_SINE;
            q2   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                lin2 <= lin_d;
                m2   <= m1;
                q2   <= p1[PHASE_W-1];
            end
        end
    end

    // Stage 3: output register holds its value while no valid sample arrives
    logic [DATA_W-1:0] sine_d;

    assign sine_d = q2 ? MID - {1'b0, mag} : MID + {1'b0, mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_out   <= '0;
            wave_valid <= 1'b0;
        end else begin
            wave_valid <= v2;
            if (v2)
                wave_out <= (m2 == MODE_SINE) ? sine_d : lin2;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: immediate-update and wrap-aligned instances
// driven side by side with hand-computed vectors.
module tb_dds_wave_gen;
    import dds_pkg::*;

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned PHASE_W = 12;
    localparam int unsigned DATA_W  = 10;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync_clr = 1'b0;
    logic cfg_valid0 = 1'b0, cfg_valid1 = 1'b0;
    logic [ACC_W-1:0]   cfg_fw   = '0;
    logic [PHASE_W-1:0] cfg_poff = '0;
    logic [1:0]         cfg_mode = '0;
    logic cfg_ready0, cfg_ready1, wave_valid0, wave_valid1, wrap0, wrap1;
    logic [DATA_W-1:0] wave_out0, wave_out1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dds_wave_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W), .UPDATE_AT_WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .cfg_valid(cfg_valid0), .cfg_ready(cfg_ready0), .cfg_fw(cfg_fw),
        .cfg_poff(cfg_poff), .cfg_mode(cfg_mode),
        .wave_out(wave_out0), .wave_valid(wave_valid0), .wrap(wrap0)
    );

    dds_wave_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W), .UPDATE_AT_WRAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1), .cfg_fw(cfg_fw),
        .cfg_poff(cfg_poff), .cfg_mode(cfg_mode),
        .wave_out(wave_out1), .wave_valid(wave_valid1), .wrap(wrap1)
    );

    typedef struct {
        logic              cv;
        logic [1:0]        mode;
        logic              en;
        logic [DATA_W-1:0] wave;
        logic              valid;
        logic              wrap;
    } vec_t;

    vec_t tv[30];
    int   exp_saw[18];

    function automatic vec_t mk(input bit cv, input logic [1:0] md, input bit e,
                                input int w, input bit v, input bit wr);
        vec_t r;
        r.cv    = cv;
        r.mode  = md;
        r.en    = e;
        r.wave  = w[DATA_W-1:0];
        r.valid = v;
        r.wrap  = wr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        sync_clr   = 1'b0;
        cfg_valid0 = 1'b0;
        cfg_valid1 = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // fw = 2^30, four samples per period; mode switched at wrap-aligned points
        tv[0]  = mk(1, MODE_SINE, 0,    0, 0, 0);
        tv[1]  = mk(0, MODE_SINE, 1,    0, 0, 0);
        tv[2]  = mk(0, MODE_SINE, 1,    0, 0, 0);
        tv[3]  = mk(0, MODE_SINE, 1,  512, 1, 0);
        tv[4]  = mk(0, MODE_SINE, 1, 1023, 1, 1);
        tv[5]  = mk(0, MODE_SINE, 1,  512, 1, 0);
        tv[6]  = mk(0, MODE_SINE, 1,    1, 1, 0);
        tv[7]  = mk(0, MODE_SINE, 1,  512, 1, 0);
        tv[8]  = mk(1, MODE_SAW,  1, 1023, 1, 1);
        tv[9]  = mk(0, MODE_SAW,  1,  512, 1, 0);
        tv[10] = mk(0, MODE_SAW,  1,    1, 1, 0);
        tv[11] = mk(0, MODE_SAW,  1,    0, 1, 0);
        tv[12] = mk(1, MODE_TRI,  1,  256, 1, 1);
        tv[13] = mk(0, MODE_TRI,  1,  512, 1, 0);
        tv[14] = mk(0, MODE_TRI,  1,  768, 1, 0);
        tv[15] = mk(0, MODE_TRI,  1,    0, 1, 0);
        tv[16] = mk(1, MODE_SQR,  1,  512, 1, 1);
        tv[17] = mk(0, MODE_SQR,  1, 1023, 1, 0);
        tv[18] = mk(0, MODE_SQR,  1,  511, 1, 0);
        tv[19] = mk(0, MODE_SQR,  1,    0, 1, 0);
        tv[20] = mk(1, MODE_SINE, 1,    0, 1, 1);
        tv[21] = mk(0, MODE_SINE, 1, 1023, 1, 0);
        tv[22] = mk(0, MODE_SINE, 1, 1023, 1, 0);
        tv[23] = mk(0, MODE_SINE, 1,  512, 1, 0);
        tv[24] = mk(0, MODE_SINE, 1, 1023, 1, 1);
        tv[25] = mk(0, MODE_SINE, 1,  512, 1, 0);
        tv[26] = mk(0, MODE_SINE, 0,    1, 1, 0);
        tv[27] = mk(0, MODE_SINE, 0,  512, 1, 0);
        tv[28] = mk(0, MODE_SINE, 0,  512, 0, 0);
        tv[29] = mk(0, MODE_SINE, 0,  512, 0, 0);

        // sawtooth samples after edges 3..20 of the wrap-aligned sequence
        exp_saw = '{0, 128, 256, 384, 512, 640, 768, 896,
                    0, 256, 512, 768, 0, 256, 512, 768, 0, 512};

        tick();
        tick();
        chk("rst.wave0",  wave_out0,   0);
        chk("rst.valid0", wave_valid0, 0);
        chk("rst.wrap0",  wrap0,       0);
        chk("rst.ready0", cfg_ready0,  1);
        chk("rst.ready1", cfg_ready1,  1);
        rst_n = 1'b1;

        cfg_fw   = 32'h4000_0000;
        cfg_poff = '0;
        for (int i = 0; i < 30; i++) begin
            cfg_valid0 = tv[i].cv;
            cfg_mode   = tv[i].mode;
            en         = tv[i].en;
            tick();
            chk($sformatf("tbl%0d.wave",  i), wave_out0,   tv[i].wave);
            chk($sformatf("tbl%0d.valid", i), wave_valid0, tv[i].valid);
            chk($sformatf("tbl%0d.wrap",  i), wrap0,       tv[i].wrap);
            chk($sformatf("tbl%0d.ready", i), cfg_ready0,  1);
        end
        cfg_valid0 = 1'b0;

        // fw=0 with quarter-period offset, applied through sync_clr
        do_reset();
        cfg_fw     = '0;
        cfg_poff   = 12'd1024;
        cfg_mode   = MODE_SINE;
        cfg_valid1 = 1'b1;
        tick();
        chk("poff.pend_ready", cfg_ready1, 0);
        cfg_valid1 = 1'b0;
        sync_clr   = 1'b1;
        tick();
        chk("poff.clr_ready", cfg_ready1, 1);
        sync_clr = 1'b0;
        en       = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("poff%0d.valid", k), wave_valid1, (k >= 3) ? 1 : 0);
            chk($sformatf("poff%0d.wrap",  k), wrap1,       0);
            if (k >= 3)
                chk($sformatf("poff%0d.wave", k), wave_out1, 1023);
        end

        // fw=0 never wraps, so the offer stays pending until sync_clr
        cfg_fw     = 32'h2000_0000;
        cfg_poff   = '0;
        cfg_mode   = MODE_SAW;
        cfg_valid1 = 1'b1;
        tick();
        cfg_valid1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d.ready", k), cfg_ready1, 0);
            tick();
        end
        sync_clr = 1'b1;
        tick();
        chk("clr.ready", cfg_ready1, 1);
        chk("clr.wrap",  wrap1,      0);
        sync_clr = 1'b0;

        // fw 2^29 -> 2^30 offered mid-period, then 2^31 offered on a wrap edge
        for (int m = 1; m <= 20; m++) begin
            if (m == 3) begin
                cfg_fw     = 32'h4000_0000;
                cfg_valid1 = 1'b1;
            end else if (m == 12) begin
                cfg_fw     = 32'h8000_0000;
                cfg_valid1 = 1'b1;
            end else begin
                cfg_valid1 = 1'b0;
            end
            tick();
            chk($sformatf("aw%0d.wrap", m), wrap1,
                (m == 8 || m == 12 || m == 16 || m == 18 || m == 20) ? 1 : 0);
            chk($sformatf("aw%0d.ready", m), cfg_ready1,
                ((m >= 3 && m <= 7) || (m >= 12 && m <= 15)) ? 0 : 1);
            if (m >= 3)
                chk($sformatf("aw%0d.wave", m), wave_out1, exp_saw[m-3]);
        end
        cfg_valid1 = 1'b0;

        // maximal frequency word: carry on every accumulate but the first
        do_reset();
        cfg_fw     = '1;
        cfg_poff   = '0;
        cfg_mode   = MODE_SAW;
        cfg_valid0 = 1'b1;
        tick();
        cfg_valid0 = 1'b0;
        en         = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("max%0d.wrap", k), wrap0, (k >= 2) ? 1 : 0);
            if (k >= 3)
                chk($sformatf("max%0d.wave", k), wave_out0, (k == 3) ? 0 : 1023);
        end

        // asynchronous reset mid-cycle with a config pending
        cfg_fw     = 32'h0000_1234;
        cfg_valid1 = 1'b1;
        tick();
        cfg_valid1 = 1'b0;
        chk("arst.pre_ready1", cfg_ready1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.wave0",  wave_out0,   0);
        chk("arst.valid0", wave_valid0, 0);
        chk("arst.wrap0",  wrap0,       0);
        chk("arst.ready0", cfg_ready0,  1);
        chk("arst.wave1",  wave_out1,   0);
        chk("arst.valid1", wave_valid1, 0);
        chk("arst.ready1", cfg_ready1,  1);
        tick();
        en    = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst.post_ready1", cfg_ready1,  1);
        chk("arst.post_wrap1",  wrap1,       0);
        chk("arst.post_valid0", wave_valid0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
